// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Contents:
//   state_t  : sequencer FSM states (IDLE, ISSUE, RESP)
//   OPER_W   : opcode width forwarded to the ALU
//   DEF_WIDTH: default operand/result width
//   SETTLE_W : settle counter width (covers SETTLE_CYCLES 1..15)
package alu_seq_pkg;

  localparam int unsigned OPER_W    = 3;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned SETTLE_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_acc.sv
// Accumulator and carry-flag register with the ALU operand-a and
// carry-in selection muxes.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_clr       : clear accumulator and carry (also zeroes the values
//                 presented to the muxes in the same cycle)
//   i_load      : load accumulator/carry from i_sum/i_c_out
//   i_sum       : result sum to load
//   i_c_out     : result carry to load
//   i_cmd_a     : command operand a
//   i_cmd_c_in  : command explicit carry-in
//   i_src_acc   : 1 selects accumulator as operand a
//   i_chain     : 1 selects stored carry as carry-in
//   o_a         : selected operand a
//   o_c_in      : selected carry-in
module alu_seq_acc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_c_out,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic             i_cmd_c_in,
  input  logic             i_src_acc,
  input  logic             i_chain,
  output logic [WIDTH-1:0] o_a,
  output logic             o_c_in
);

  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] w_acc_eff;
  logic             w_carry_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_clr) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_load) begin
      r_acc   <= i_sum;
      r_carry <= i_c_out;
    end
  end

  // A clear in the accept cycle must be visible to that same command,
  // so the muxes see the post-clear values rather than the registers.
  always_comb begin
    w_acc_eff   = i_clr ? '0 : r_acc;
    w_carry_eff = i_clr ? 1'b0 : r_carry;
    o_a         = i_src_acc ? w_acc_eff : i_cmd_a;
    o_c_in      = i_chain ? w_carry_eff : i_cmd_c_in;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequential initiator for a combinational ALU. Accepts commands over a
// valid/ready handshake, drives registered operands onto the ALU, waits
// SETTLE_CYCLES, captures sum/carry and returns them over a valid/ready
// response channel. An internal accumulator/carry flag supports
// carry-chained multi-byte arithmetic.
// Optional feature macro: ALU_SEQ_ZFLAG_EN adds output rsp_zero
// (captured sum == 0).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_oper, cmd_a, cmd_b, cmd_src_acc, cmd_chain, cmd_c_in : command
//   acc_clr               : clear accumulator/carry (IDLE only)
//   alu_oper/a/b/c_in     : registered ALU inputs
//   alu_sum, alu_c_out    : ALU results
//   rsp_valid/rsp_ready   : response handshake
//   rsp_sum, rsp_c_out    : captured result
//   rsp_zero              : captured zero flag (ALU_SEQ_ZFLAG_EN only)
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPER_W-1:0] cmd_oper,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic              cmd_src_acc,
  input  logic              cmd_chain,
  input  logic              cmd_c_in,
  input  logic              acc_clr,
  output logic [OPER_W-1:0] alu_oper,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_c_in,
  input  logic [WIDTH-1:0]  alu_sum,
  input  logic              alu_c_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_sum,
`ifdef ALU_SEQ_ZFLAG_EN
  output logic              rsp_zero,
`endif
  output logic              rsp_c_out
);

  localparam logic [SETTLE_W-1:0] CNT_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SETTLE_W-1:0] r_cnt;
  logic [OPER_W-1:0]   r_alu_oper;
  logic [WIDTH-1:0]    r_alu_a;
  logic [WIDTH-1:0]    r_alu_b;
  logic                r_alu_c_in;
  logic [WIDTH-1:0]    r_rsp_sum;
  logic                r_rsp_c_out;
  logic                w_accept;
  logic                w_capture;
  logic                w_clr;
  logic [WIDTH-1:0]    w_sel_a;
  logic                w_sel_c_in;

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        w_clr     = acc_clr;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_alu_oper  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_c_in  <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_c_out <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt      <= CNT_INIT;
        r_alu_oper <= cmd_oper;
        r_alu_a    <= w_sel_a;
        r_alu_b    <= cmd_b;
        r_alu_c_in <= w_sel_c_in;
      end else if (r_state == ISSUE && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rsp_sum   <= alu_sum;
        r_rsp_c_out <= alu_c_out;
      end
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  logic r_rsp_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_zero <= 1'b0;
    end else if (w_capture) begin
      r_rsp_zero <= (alu_sum == '0);
    end
  end

  assign rsp_zero = r_rsp_zero;
`endif

  alu_seq_acc #(
    .WIDTH(WIDTH)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_load    (w_capture),
    .i_sum     (alu_sum),
    .i_c_out   (alu_c_out),
    .i_cmd_a   (cmd_a),
    .i_cmd_c_in(cmd_c_in),
    .i_src_acc (cmd_src_acc),
    .i_chain   (cmd_chain),
    .o_a       (w_sel_a),
    .o_c_in    (w_sel_c_in)
  );

  assign alu_oper  = r_alu_oper;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_c_in  = r_alu_c_in;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_c_out = r_rsp_c_out;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer. Two instances: u_dut with
// SETTLE_CYCLES=1 and u_dut3 with SETTLE_CYCLES=3, each driving its own
// adder model (sum,c_out = a+b+c_in). Command/response inputs are shared;
// u_dut3 is held in reset until the settle test.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, rst3_n;
  logic       cmd_valid, cmd_src_acc, cmd_chain, cmd_c_in, acc_clr, rsp_ready;
  logic [2:0] cmd_oper;
  logic [7:0] cmd_a, cmd_b;

  logic       cmd_ready, alu_c_in, alu_c_out, rsp_valid, rsp_c_out;
  logic [2:0] alu_oper;
  logic [7:0] alu_a, alu_b, alu_sum, rsp_sum;

  logic       cmd_ready3, alu_c_in3, alu_c_out3, rsp_valid3, rsp_c_out3;
  logic [2:0] alu_oper3;
  logic [7:0] alu_a3, alu_b3, alu_sum3, rsp_sum3;

`ifdef ALU_SEQ_ZFLAG_EN
  logic       rsp_zero, rsp_zero3;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int edges;

  always #5 clk = ~clk;

  assign {alu_c_out, alu_sum}   = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
  assign {alu_c_out3, alu_sum3} = {1'b0, alu_a3} + {1'b0, alu_b3} + {8'd0, alu_c_in3};

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_oper(cmd_oper),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_src_acc(cmd_src_acc),
    .cmd_chain(cmd_chain), .cmd_c_in(cmd_c_in), .acc_clr(acc_clr),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_sum(alu_sum), .alu_c_out(alu_c_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
`ifdef ALU_SEQ_ZFLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .rsp_c_out(rsp_c_out)
  );

  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3), .cmd_oper(cmd_oper),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_src_acc(cmd_src_acc),
    .cmd_chain(cmd_chain), .cmd_c_in(cmd_c_in), .acc_clr(acc_clr),
    .alu_oper(alu_oper3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_c_in(alu_c_in3),
    .alu_sum(alu_sum3), .alu_c_out(alu_c_out3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum3),
`ifdef ALU_SEQ_ZFLAG_EN
    .rsp_zero(rsp_zero3),
`endif
    .rsp_c_out(rsp_c_out3)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one command for a single cycle; returns just after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [2:0] op, input logic src, input logic chain,
                       input logic clr);
    cmd_a = a; cmd_b = b; cmd_c_in = cin; cmd_oper = op;
    cmd_src_acc = src; cmd_chain = chain; acc_clr = clr;
    cmd_valid = 1'b1;
    chk_eq("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    tick;
    cmd_valid = 1'b0; acc_clr = 1'b0; cmd_src_acc = 1'b0; cmd_chain = 1'b0;
  endtask

  // Edges counted from the accept edge (inclusive) until rsp_valid; bounded.
  task automatic wait_rsp(input bit use3, output int n);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (use3 ? rsp_valid3 : rsp_valid) break;
      tick;
      n++;
    end
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    cmd_valid = 1'b0; cmd_src_acc = 1'b0; cmd_chain = 1'b0; cmd_c_in = 1'b0;
    acc_clr = 1'b0; rsp_ready = 1'b0; cmd_oper = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0;
    tick; tick;
    rst_n = 1'b1;

    // Reset state
    chk_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk_eq("rst_alu_a",     {24'd0, alu_a},     32'd0);
    chk_eq("rst_alu_b",     {24'd0, alu_b},     32'd0);
    chk_eq("rst_rsp_sum",   {24'd0, rsp_sum},   32'd0);

    // Basic accept: D2 + B6 = 0x188
    issue(8'hD2, 8'hB6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk_eq("basic_alu_a",  {24'd0, alu_a}, 32'hD2);
    chk_eq("basic_alu_b",  {24'd0, alu_b}, 32'hB6);
    chk_eq("basic_busy",   {31'd0, cmd_ready}, 32'd0);
    wait_rsp(1'b0, edges);
    chk_eq("basic_latency", edges, 32'd2);
    chk_eq("basic_sum",   {24'd0, rsp_sum}, 32'h88);
    chk_eq("basic_c_out", {31'd0, rsp_c_out}, 32'd1);
`ifdef ALU_SEQ_ZFLAG_EN
    chk_eq("basic_zero",  {31'd0, rsp_zero}, 32'd0);
`endif
    release_rsp;
    chk_eq("basic_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk_eq("basic_done_ready", {31'd0, cmd_ready}, 32'd1);
    chk_eq("alu_a_held_idle",  {24'd0, alu_a}, 32'hD2);

    // Chained: acc 0x88 + 0x01 + carry 1 = 0x8A
    issue(8'h55, 8'h01, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
    chk_eq("chain_alu_a",    {24'd0, alu_a},    32'h88);
    chk_eq("chain_alu_c_in", {31'd0, alu_c_in}, 32'd1);
    chk_eq("chain_alu_oper", {29'd0, alu_oper}, 32'd5);
    wait_rsp(1'b0, edges);
    chk_eq("chain_latency", edges, 32'd2);
    chk_eq("chain_sum",   {24'd0, rsp_sum},   32'h8A);
    chk_eq("chain_c_out", {31'd0, rsp_c_out}, 32'd0);

    // Back-pressure: response held, new command refused
    cmd_a = 8'h3C; cmd_b = 8'h11; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk_eq("bp_sum",   {24'd0, rsp_sum},   32'h8A);
      chk_eq("bp_ready", {31'd0, cmd_ready}, 32'd0);
      chk_eq("bp_alu_a", {24'd0, alu_a},     32'h88);
    end
    cmd_valid = 1'b0;
    release_rsp;
    chk_eq("bp_rel_valid", {31'd0, rsp_valid}, 32'd0);
    chk_eq("bp_rel_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset mid-ISSUE aborts the command and clears acc (currently 0x8A)
    issue(8'h11, 8'h22, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    chk_eq("abort_alu_a_loaded", {24'd0, alu_a}, 32'h11);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk_eq("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk_eq("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk_eq("abort_alu_a",     {24'd0, alu_a},     32'd0);
    chk_eq("abort_alu_c_in",  {31'd0, alu_c_in},  32'd0);
    chk_eq("abort_alu_oper",  {29'd0, alu_oper},  32'd0);
    edges = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rsp_valid) edges++;
    end
    chk_eq("abort_no_rsp", edges, 32'd0);
    issue(8'h99, 8'h07, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    chk_eq("abort_acc_zero",   {24'd0, alu_a},    32'd0);
    chk_eq("abort_carry_zero", {31'd0, alu_c_in}, 32'd0);
    wait_rsp(1'b0, edges);
    chk_eq("abort_next_sum", {24'd0, rsp_sum}, 32'h07);
    release_rsp;

    // Make acc/carry non-zero: FF + FF + 1 = 0x1FF
    issue(8'hFF, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    wait_rsp(1'b0, edges);
    chk_eq("pre_clr_sum",   {24'd0, rsp_sum},   32'hFF);
    chk_eq("pre_clr_c_out", {31'd0, rsp_c_out}, 32'd1);
    release_rsp;

    // Clear priority over a same-cycle accept
    issue(8'h77, 8'h05, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1);
    chk_eq("clr_alu_a",    {24'd0, alu_a},    32'd0);
    chk_eq("clr_alu_c_in", {31'd0, alu_c_in}, 32'd0);
    wait_rsp(1'b0, edges);
    chk_eq("clr_sum",   {24'd0, rsp_sum},   32'h05);
    chk_eq("clr_c_out", {31'd0, rsp_c_out}, 32'd0);
    release_rsp;

    // acc_clr ignored outside IDLE: 0x10+0x20 then acc+0x01
    issue(8'h10, 8'h20, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    acc_clr = 1'b1;
    wait_rsp(1'b0, edges);
    chk_eq("busy_clr_sum", {24'd0, rsp_sum}, 32'h30);
    release_rsp;
    acc_clr = 1'b0;
    issue(8'h00, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk_eq("busy_clr_acc_kept", {24'd0, alu_a}, 32'h30);
    wait_rsp(1'b0, edges);
    chk_eq("busy_clr_next_sum", {24'd0, rsp_sum}, 32'h31);
    release_rsp;

    // SETTLE_CYCLES=3: FF + 01 = 0x100
    rst3_n = 1'b1;
    chk_eq("s3_ready", {31'd0, cmd_ready3}, 32'd1);
    issue(8'hFF, 8'h01, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
    chk_eq("s3_alu_oper", {29'd0, alu_oper3}, 32'd7);
    wait_rsp(1'b1, edges);
    chk_eq("s3_latency", edges, 32'd4);
    chk_eq("s3_sum",   {24'd0, rsp_sum3},   32'h00);
    chk_eq("s3_c_out", {31'd0, rsp_c_out3}, 32'd1);
`ifdef ALU_SEQ_ZFLAG_EN
    chk_eq("s3_zero",  {31'd0, rsp_zero3},  32'd1);
`endif
    release_rsp;
    chk_eq("s3_done_valid", {31'd0, rsp_valid3}, 32'd0);
    chk_eq("s3_done_ready", {31'd0, cmd_ready3}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
